// File: rtl/es_pop_drain.sv
// -----------------------------------------------------------------------------
// es_pop_drain
//
// Pop-side sequencer for the expression stack (ex_stack). When a request is
// accepted it pops 1..MAX_POP entries by pulsing ESAct with ESOp=POP_OP. Each
// top-of-stack value (tosRega) is captured and then offered, one at a time, on
// a valid/ready output stream. The stack depth is checked before any pop is
// issued, so an underflow never reaches the stack.
//
// Optional feature (macro ES_POP_PEEK_EN):
//   Adds the input 'peek'. A peek request reads tosRega and then tosRegb
//   without popping. ESAct stays low and the SETTLE state is skipped. Only
//   counts of 1 or 2 are legal for a peek.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   req            start request, sampled only in IDLE
//   req_count      entries to pop (1..MAX_POP)
//   es_depth       current stack occupancy
//   tosRega        stack outA (top of stack)
//   tosRegb        stack outB (second entry), used only by peek
//   peek           (ES_POP_PEEK_EN only) read without popping
//   ESOp / ESAct   stack operation code and one-cycle action strobe
//   out_data       popped value
//   out_valid      out_data is valid
//   out_ready      downstream accepts out_data
//   busy           sequencer is not in IDLE
//   err_underflow  sticky flag for an illegal request
//   done           one-cycle pulse after the last value is accepted
// -----------------------------------------------------------------------------
module es_pop_drain #(
    parameter int         WIDTH   = 16,
    parameter int         MAX_POP = 4,
    parameter logic [1:0] POP_OP  = 2'b10,
    parameter logic [1:0] NOP_OP  = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [2:0]       req_count,
    input  logic [4:0]       es_depth,
    input  logic [WIDTH-1:0] tosRega,
    input  logic [WIDTH-1:0] tosRegb,
`ifdef ES_POP_PEEK_EN
    input  logic             peek,
`endif
    output logic [1:0]       ESOp,
    output logic             ESAct,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err_underflow,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_SETTLE,
        S_FINISH
    } state_t;

    state_t     state;
    logic [2:0] remaining;
    logic       req_illegal;
    logic       pop_now;

`ifdef ES_POP_PEEK_EN
    logic peek_mode;
    logic peek_second;
`else
    logic unused_tosb;
    assign unused_tosb = ^tosRegb;
`endif

    // A request is rejected when the count is zero, larger than MAX_POP, or
    // larger than the current depth. es_depth is only looked at here, in IDLE.
    always_comb begin
        req_illegal = 1'b0;
        if (req_count == 3'd0)
            req_illegal = 1'b1;
        if (int'(req_count) > MAX_POP)
            req_illegal = 1'b1;
        if ({2'b00, req_count} > es_depth)
            req_illegal = 1'b1;
`ifdef ES_POP_PEEK_EN
        if (peek && (req_count > 3'd2))
            req_illegal = 1'b1;
`endif
    end

    // The pop strobe exists only for the LOAD cycle, so the stack pops on the
    // same edge that captures the old top of stack into out_data.
    always_comb begin
        pop_now = (state == S_LOAD);
`ifdef ES_POP_PEEK_EN
        if (peek_mode)
            pop_now = 1'b0;
`endif
    end

    assign ESAct = pop_now;
    assign ESOp  = pop_now ? POP_OP : NOP_OP;
    assign busy  = (state != S_IDLE);

    // Main sequencer: state, remaining count, and the registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            remaining     <= 3'd0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            err_underflow <= 1'b0;
            done          <= 1'b0;
`ifdef ES_POP_PEEK_EN
            peek_mode     <= 1'b0;
            peek_second   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    out_valid <= 1'b0;
                    if (req) begin
                        if (req_illegal) begin
                            err_underflow <= 1'b1;
                        end else begin
                            err_underflow <= 1'b0;
                            remaining     <= req_count;
                            state         <= S_LOAD;
`ifdef ES_POP_PEEK_EN
                            peek_mode     <= peek;
                            peek_second   <= 1'b0;
`endif
                        end
                    end
                end

                S_LOAD: begin
`ifdef ES_POP_PEEK_EN
                    // A peek reads outA first and outB second; a pop always
                    // reads outA because the stack has shifted by then.
                    out_data    <= (peek_mode && peek_second) ? tosRegb : tosRega;
                    peek_second <= 1'b1;
`else
                    out_data    <= tosRega;
`endif
                    if (remaining != 3'd0)
                        remaining <= remaining - 3'd1;
                    out_valid <= 1'b1;
                    state     <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (remaining == 3'd0) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
`ifdef ES_POP_PEEK_EN
                            state <= peek_mode ? S_LOAD : S_SETTLE;
`else
                            state <= S_SETTLE;
`endif
                        end
                    end
                end

                // One idle cycle so the stack's registered outA reflects the pop.
                S_SETTLE: begin
                    state <= S_LOAD;
                end

                S_FINISH: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_es_pop_drain.sv
// -----------------------------------------------------------------------------
// tb_es_pop_drain
//
// Directed testbench for es_pop_drain. A small behavioural stack drives
// tosRega/tosRegb/es_depth and pops whenever ESAct is seen with ESOp=POP.
// -----------------------------------------------------------------------------
module tb_es_pop_drain;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             req;
    logic [2:0]       req_count;
    logic [4:0]       es_depth;
    logic [WIDTH-1:0] tosRega;
    logic [WIDTH-1:0] tosRegb;
    logic [1:0]       ESOp;
    logic             ESAct;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err_underflow;
    logic             done;
`ifdef ES_POP_PEEK_EN
    logic             peek;
`endif

    // Behavioural stack: mem is written by the stimulus, sp only here.
    logic [WIDTH-1:0] mem [0:7];
    logic [4:0]       sp;
    logic             set_sp;
    logic [4:0]       set_sp_val;
    int               act_count;
    int               bad_op_count;

    int checks;
    int errors;

    es_pop_drain #(
        .WIDTH  (WIDTH),
        .MAX_POP(4),
        .POP_OP (2'b10),
        .NOP_OP (2'b00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_count    (req_count),
        .es_depth     (es_depth),
        .tosRega      (tosRega),
        .tosRegb      (tosRegb),
`ifdef ES_POP_PEEK_EN
        .peek         (peek),
`endif
        .ESOp         (ESOp),
        .ESAct        (ESAct),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .err_underflow(err_underflow),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign es_depth = sp;
    assign tosRega  = (sp > 5'd0) ? mem[sp[2:0] - 3'd1] : '0;
    assign tosRegb  = (sp > 5'd1) ? mem[sp[2:0] - 3'd2] : '0;

    always @(posedge clk) begin
        if (set_sp)
            sp <= set_sp_val;
        else if (ESAct && (ESOp == 2'b10) && (sp != 5'd0))
            sp <= sp - 5'd1;
        if (ESAct)
            act_count <= act_count + 1;
        if (ESAct && (ESOp != 2'b10))
            bad_op_count <= bad_op_count + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic load_stack(input logic [4:0] depth);
        set_sp     = 1'b1;
        set_sp_val = depth;
        tick;
        set_sp     = 1'b0;
    endtask

    int         acts_before;
    int         vals;
    int         first_valid_at;
    int         done_cnt;
    int         done_at;
    int         unstable;
    logic [WIDTH-1:0] v0;
    logic [WIDTH-1:0] v1;

    initial begin
        checks       = 0;
        errors       = 0;
        act_count    = 0;
        bad_op_count = 0;
        sp           = 5'd0;
        set_sp       = 1'b0;
        set_sp_val   = 5'd0;
        reset        = 1'b1;
        req          = 1'b0;
        req_count    = 3'd0;
        out_ready    = 1'b0;
        v0           = '0;
        v1           = '0;
`ifdef ES_POP_PEEK_EN
        peek         = 1'b0;
`endif
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset state
        tick;
        tick;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_esact", 32'(ESAct), 32'd0);
        check("rst_esop", 32'(ESOp), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick;

        // Drain two entries: stack 0x0005, 0x0003 (TOS)
        $display("[TB] drain two entries");
        mem[0] = 16'h0005;
        mem[1] = 16'h0003;
        load_stack(5'd2);
        out_ready   = 1'b1;
        req_count   = 3'd2;
        req         = 1'b1;
        acts_before = act_count;
        tick;
        req = 1'b0;
        check("load_esact", 32'(ESAct), 32'd1);
        check("load_esop", 32'(ESOp), 32'h2);
        check("load_busy", 32'(busy), 32'd1);
        vals = 0; done_cnt = 0; done_at = -1; first_valid_at = -1;
        // Index 0 is the first LOAD cycle; FINISH lands on index 5.
        for (int i = 0; i < 12; i++) begin
            if (out_valid && first_valid_at < 0) first_valid_at = i;
            if (out_valid && out_ready) begin
                if (vals == 0) v0 = out_data; else v1 = out_data;
                vals++;
            end
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            tick;
        end
        check("drain_first_valid", 32'(first_valid_at), 32'd1);
        check("drain_nvals", 32'(vals), 32'd2);
        check("drain_v0", 32'(v0), 32'h0003);
        check("drain_v1", 32'(v1), 32'h0005);
        check("drain_acts", 32'(act_count - acts_before), 32'd2);
        check("drain_badop", 32'(bad_op_count), 32'd0);
        check("drain_done_cnt", 32'(done_cnt), 32'd1);
        check("drain_done_at", 32'(done_at), 32'd5);
        check("drain_idle", 32'(busy), 32'd0);
        check("drain_depth", 32'(es_depth), 32'd0);

        // Underflow: depth 1, count 2
        $display("[TB] underflow request");
        mem[0] = 16'h0009;
        load_stack(5'd1);
        acts_before = act_count;
        req_count   = 3'd2;
        req         = 1'b1;
        tick;
        req = 1'b0;
        check("uf_err", 32'(err_underflow), 32'd1);
        check("uf_busy", 32'(busy), 32'd0);
        check("uf_esact", 32'(ESAct), 32'd0);
        tick;
        tick;
        check("uf_acts", 32'(act_count - acts_before), 32'd0);
        check("uf_err_sticky", 32'(err_underflow), 32'd1);
        // Count above MAX_POP is rejected even with enough depth
        load_stack(5'd7);
        req_count = 3'd5;
        req       = 1'b1;
        tick;
        req = 1'b0;
        check("max_busy", 32'(busy), 32'd0);
        check("max_err", 32'(err_underflow), 32'd1);
        // Legal request clears the flag
        load_stack(5'd1);
        req_count = 3'd1;
        req       = 1'b1;
        tick;
        req = 1'b0;
        check("clr_err", 32'(err_underflow), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) tick;
        check("clr_idle", 32'(busy), 32'd0);

        // Stall in PRESENT for 5 cycles
        $display("[TB] stalled output");
        mem[0] = 16'h00A5;
        load_stack(5'd1);
        out_ready   = 1'b0;
        acts_before = act_count;
        req_count   = 3'd1;
        req         = 1'b1;
        tick;
        req = 1'b0;
        tick;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid === 1'b1 && out_data === 16'h00A5 && ESAct === 1'b0)) unstable++;
            tick;
        end
        check("stall_stable", 32'(unstable), 32'd0);
        check("stall_acts", 32'(act_count - acts_before), 32'd1);
        check("stall_no_done", 32'(done), 32'd0);
        out_ready = 1'b1;
        tick;
        check("stall_done", 32'(done), 32'd1);
        check("stall_valid_low", 32'(out_valid), 32'd0);
        tick;
        check("stall_done_pulse", 32'(done), 32'd0);
        check("stall_idle", 32'(busy), 32'd0);

        // req held while busy is ignored
        $display("[TB] request while busy");
        mem[0] = 16'h0001;
        mem[1] = 16'h0002;
        mem[2] = 16'h0003;
        load_stack(5'd3);
        acts_before = act_count;
        req_count   = 3'd2;
        req         = 1'b1;
        tick;
        req_count = 3'd3;
        for (int i = 0; i < 5; i++) tick;
        req = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check("busyreq_acts", 32'(act_count - acts_before), 32'd2);
        check("busyreq_depth", 32'(es_depth), 32'd1);
        check("busyreq_idle", 32'(busy), 32'd0);

        // Reset in the middle of PRESENT
        $display("[TB] reset mid-sequence");
        mem[0] = 16'h1234;
        load_stack(5'd1);
        out_ready = 1'b0;
        req_count = 3'd1;
        req       = 1'b1;
        tick;
        req = 1'b0;
        tick;
        check("mid_valid_before", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_esact", 32'(ESAct), 32'd0);
        check("mid_data", 32'(out_data), 32'd0);
        check("mid_depth", 32'(es_depth), 32'd0);
        tick;
        reset = 1'b0;
        tick;
        check("mid_after_busy", 32'(busy), 32'd0);

`ifdef ES_POP_PEEK_EN
        // Peek two entries without popping
        $display("[TB] peek two entries");
        mem[0] = 16'h0002;
        mem[1] = 16'h0007;
        load_stack(5'd2);
        out_ready   = 1'b1;
        acts_before = act_count;
        peek        = 1'b1;
        req_count   = 3'd2;
        req         = 1'b1;
        tick;
        req  = 1'b0;
        peek = 1'b0;
        vals = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_ready) begin
                if (vals == 0) v0 = out_data; else v1 = out_data;
                vals++;
            end
            tick;
        end
        check("peek_nvals", 32'(vals), 32'd2);
        check("peek_v0", 32'(v0), 32'h0007);
        check("peek_v1", 32'(v1), 32'h0002);
        check("peek_acts", 32'(act_count - acts_before), 32'd0);
        check("peek_depth", 32'(es_depth), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
